// File: rtl/cnn_bram_sdp.sv
// Simple-dual-port RAM: per-lane write enables, RD_LAT 1/2, and a zeroing pass after reset.
// Optional macro CNN_BRAM_WR_FWD_EN: same-address read/write returns the new data per lane.

module cnn_bram_sdp_lane #(
  parameter int LW     = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LW-1:0]     rdata
);
  logic [LW-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // rdata only loads on an accepted read, so it doubles as the held doutb at RD_LAT=1
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) begin
`ifdef CNN_BRAM_WR_FWD_EN
      if (we && waddr == raddr) rdata <= wdata;
      else                      rdata <= mem[raddr];
`else
      rdata <= mem[raddr];
`endif
    end
endmodule

module cnn_bram_sdp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int LANES  = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [LANES-1:0]  wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld,
  output logic              busy
);
  localparam int LW = DATA_W / LANES;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             clr_cnt;
  logic                          clearing, rd_acc, wr_acc;
  logic [ADDR_W-1:0]             waddr;
  logic [LANES-1:0][LW-1:0]      dina_l, rdata_l;
  logic [RD_LAT:1]               vld_pipe;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_cnt == '1) begin
        state <= READY;
        busy  <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end

  assign clearing = (state == CLEAR);
  assign rd_acc   = !clearing && enb;
  assign wr_acc   = !clearing && ena;
  assign waddr    = clearing ? clr_cnt : addra;
  assign dina_l   = dina;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cnn_bram_sdp_lane #(.LW(LW), .ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (clearing | (wr_acc & wea[i])),
      .waddr (waddr),
      .wdata (clearing ? '0 : dina_l[i]),
      .re    (rd_acc),
      .raddr (addrb),
      .rdata (rdata_l[i])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_acc;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end

  assign doutb_vld = vld_pipe[RD_LAT];

  if (RD_LAT == 2) begin : g_oreg
    logic [DATA_W-1:0] doutb_q;
    always_ff @(posedge clk or posedge rst)
      if (rst)              doutb_q <= '0;
      else if (vld_pipe[1]) doutb_q <= rdata_l;
    assign doutb = doutb_q;
  end else begin : g_noreg
    assign doutb = rdata_l;
  end
endmodule

// File: tb/tb_cnn_bram_sdp.sv
// Bench for cnn_bram_sdp: RD_LAT=1 and RD_LAT=2 instances share stimulus; a word-level
// memory model predicts busy, doutb and doutb_vld for both.
module tb_cnn_bram_sdp;
  localparam int DW = 16, AW = 4, NL = 2, LW = 8, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, ena, enb;
  logic [NL-1:0] wea;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina;
  logic [DW-1:0] d1, d2;
  logic          v1, v2, b1, b2;

  always #5 clk = ~clk;

  cnn_bram_sdp #(.DATA_W(DW), .ADDR_W(AW), .LANES(NL), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(d1), .doutb_vld(v1), .busy(b1));

  cnn_bram_sdp #(.DATA_W(DW), .ADDR_W(AW), .LANES(NL), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(d2), .doutb_vld(v2), .busy(b2));

  // reference model
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left;
  logic          e_busy, e_v1, e_v2, p_v;
  logic [DW-1:0] e_d1, e_d2, p_d;
  int            n_cmp = 0, n_bad = 0;

  task automatic model_reset();
    clr_left = DEPTH;
    e_busy = 1'b1; e_v1 = 1'b0; e_v2 = 1'b0; p_v = 1'b0;
    e_d1 = '0; e_d2 = '0; p_d = '0;
  endtask

  // drive one cycle at the negedge, advance the model at the posedge, return #1 later
  task automatic drive(input logic a_en, input logic [NL-1:0] a_we, input logic [AW-1:0] a_ad,
                       input logic [DW-1:0] a_d, input logic b_en, input logic [AW-1:0] b_ad);
    logic          r_v;
    logic [DW-1:0] r_d, w;
    @(negedge clk);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d; enb = b_en; addrb = b_ad;
    @(posedge clk);
    r_v = (clr_left == 0) && b_en;
    r_d = mem_m[b_ad];
`ifdef CNN_BRAM_WR_FWD_EN
    if (clr_left == 0 && a_en && a_ad == b_ad)
      for (int l = 0; l < NL; l++) if (a_we[l]) r_d[l*LW +: LW] = a_d[l*LW +: LW];
`endif
    if (clr_left == 0 && a_en) begin
      w = mem_m[a_ad];
      for (int l = 0; l < NL; l++) if (a_we[l]) w[l*LW +: LW] = a_d[l*LW +: LW];
      mem_m[a_ad] = w;
    end
    if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = '0;
      clr_left--;
    end
    e_busy = (clr_left != 0);
    e_v2 = p_v; if (p_v) e_d2 = p_d;
    e_v1 = r_v; if (r_v) e_d1 = r_d;
    p_v = r_v; p_d = r_d;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ena = 0; wea = '0; addra = '0; dina = '0; enb = 0; addrb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
      n_bad++; $display("FAIL reset lat1: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", b1, v1, d1, e_busy, e_v1, e_d1);
    end
    n_cmp++;
    if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
      n_bad++; $display("FAIL reset lat2: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", b2, v2, d2, e_busy, e_v2, e_d2);
    end
    rst = 1'b0;
  endtask

  // random port traffic during the clear must be ignored; then every word reads zero
  task automatic test_clear();
    for (int i = 0; i < DEPTH + DEPTH + 2; i++) begin
      if (i < DEPTH)
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else
        drive(0, '0, '0, '0, (i < 2*DEPTH), 4'(i - DEPTH));
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL clear lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL clear lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1, 2'b11, 4'd2, 16'hA5A5, 0, '0);
        1:       drive(0, '0, '0, '0, 1, 4'd2);
        default: drive(0, '0, '0, '0, 0, '0);
      endcase
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL write_read lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL write_read lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
    n_cmp++;
    if (e_d1 !== 16'hA5A5) begin
      n_bad++; $display("FAIL write_read model: got %h want a5a5", e_d1);
    end
  endtask

  task automatic test_lane();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1, 2'b11, 4'd5, 16'h1234, 0, '0);
        1:       drive(1, 2'b01, 4'd5, 16'hFFEE, 0, '0);
        2:       drive(0, '0, '0, '0, 1, 4'd5);
        default: drive(0, '0, '0, '0, 0, '0);
      endcase
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL lane lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL lane lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
    n_cmp++;
    if (d2 !== 16'h12EE) begin
      n_bad++; $display("FAIL lane value: got %h want 12ee", d2);
    end
  endtask

  task automatic test_back_to_back();
    int streak = 0;
    for (int i = 0; i < DEPTH; i++) drive(1, 2'b11, 4'(i), 16'h0100 + 16'(i), 0, '0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(0, '0, '0, '0, (i < DEPTH), 4'(i));
      if (v2) streak++;
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL b2b lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL b2b lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
    n_cmp++;
    if (streak != DEPTH) begin
      n_bad++; $display("FAIL b2b streak: got %0d want %0d", streak, DEPTH);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
`ifdef CNN_BRAM_WR_FWD_EN
    want = 16'h2222;
`else
    want = 16'h1111;
`endif
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1, 2'b11, 4'd7, 16'h1111, 0, '0);
        1:       drive(1, 2'b11, 4'd7, 16'h2222, 1, 4'd7);
        default: drive(0, '0, '0, '0, 0, '0);
      endcase
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL collision lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL collision lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
    n_cmp++;
    if (d1 !== want) begin
      n_bad++; $display("FAIL collision value: got %h want %h", d1, want);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15)));
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL random lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL random lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 2'b11, 4'd2, 16'hBEEF, 0, '0);
    drive(0, '0, '0, '0, 1, 4'd2);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(posedge clk);
      #1;
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL reset_mid lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL reset_mid lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(0, '0, '0, '0, (i == DEPTH), 4'd2);
      n_cmp++;
      if ({b1, v1, d1} !== {e_busy, e_v1, e_d1}) begin
        n_bad++; $display("FAIL reclear lat1 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b1, v1, d1, e_busy, e_v1, e_d1);
      end
      n_cmp++;
      if ({b2, v2, d2} !== {e_busy, e_v2, e_d2}) begin
        n_bad++; $display("FAIL reclear lat2 i=%0d: got busy=%b vld=%b d=%h want busy=%b vld=%b d=%h", i, b2, v2, d2, e_busy, e_v2, e_d2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 0; wea = '0; addra = '0; dina = '0; enb = 0; addrb = '0;
    test_reset();
    test_clear();
    test_write_read();
    test_lane();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
